// File: rtl/pgm_video_pkg.sv
// pgm_video_pkg
//   Shared types and helpers for the sprite line buffer.
//   - wr_state_e  : writer FSM states (idle / expanding a pixel run)
//   - PIX_PER_RUN : pixels carried by one 64-bit run command
//   - LAST_K      : index of the final pixel in a run
//   - pix_field() : extracts one 5-bit colour field from a run word
package pgm_video_pkg;

   typedef enum logic {
      WR_IDLE   = 1'b0,
      WR_EXPAND = 1'b1
   } wr_state_e;

   localparam int         PIX_PER_RUN = 12;
   localparam logic [3:0] LAST_K      = 4'(PIX_PER_RUN - 1);

   // A run is four 16-bit A-ROM words, three 5-bit pixels per word, with the
   // top bit of each word unused. Pixel k = 3j+i lives at bit 16j+5i.
   // With flip set, the pixel at offset k is taken from field 11-k.
   function automatic logic [4:0] pix_field(input logic [63:0] data,
                                            input logic [3:0]  idx,
                                            input logic        flip);
      logic [3:0] eff;
      logic [5:0] lsb;
      eff = flip ? (LAST_K - idx) : idx;
      case (eff)
         4'd0:    lsb = 6'd0;
         4'd1:    lsb = 6'd5;
         4'd2:    lsb = 6'd10;
         4'd3:    lsb = 6'd16;
         4'd4:    lsb = 6'd21;
         4'd5:    lsb = 6'd26;
         4'd6:    lsb = 6'd32;
         4'd7:    lsb = 6'd37;
         4'd8:    lsb = 6'd42;
         4'd9:    lsb = 6'd48;
         4'd10:   lsb = 6'd53;
         4'd11:   lsb = 6'd58;
         default: lsb = 6'd0;
      endcase
      return data[lsb +: 5];
   endfunction

endpackage

// File: rtl/pgm_linebuf_bank.sv
// pgm_linebuf_bank
//   One line bank: LINE_W data entries plus one occupancy bit per entry.
//   Ports:
//     clk, reset_n      - clock, asynchronous active-low reset (occupancy only)
//     we, waddr, wdata  - write port; a write lands only on an empty entry,
//                         so the first writer of a pixel wins
//     clr, raddr        - read-and-clear port; clr empties entry raddr
//     rdata             - combinational read: entry if occupied, else 0
//   Entry data is never reset; the occupancy bits hide stale contents.
module pgm_linebuf_bank
   import pgm_video_pkg::*;
#(
   parameter int LINE_W = 448,
   parameter int EW     = 10,
   parameter int AW     = $clog2(LINE_W)
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [EW-1:0] wdata,
   input  logic          clr,
   input  logic [AW-1:0] raddr,
   output logic [EW-1:0] rdata
);

   logic [LINE_W-1:0] occ;
   logic [EW-1:0]     mem [LINE_W];
   logic              wr_hit;

   assign wr_hit = we && !occ[waddr];

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         occ <= '0;
      end else begin
         if (wr_hit) occ[waddr] <= 1'b1;
         if (clr)    occ[raddr] <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_hit) mem[waddr] <= wdata;
   end

   assign rdata = occ[raddr] ? mem[raddr] : '0;

endmodule

// File: rtl/pgm_sprite_linebuf.sv
// pgm_sprite_linebuf
//   Double-buffered sprite line buffer. The sprite engine streams pixel-run
//   commands (12 pixels each) into the write bank while the display reads and
//   clears the other bank; line_swap exchanges the two banks.
//   Ports:
//     clk, reset_n                 - clock, asynchronous active-low reset
//     line_swap                    - one-cycle pulse at line end, swaps banks
//     wr_valid/wr_ready            - run command handshake; a command is taken
//                                    on a cycle where both are high
//     wr_x, wr_pal, wr_flipx,
//     wr_prio, wr_data             - run command payload
//     rd_en, rd_x                  - display read strobe and X
//     rd_valid, rd_pix, rd_prio    - read result one cycle after rd_en
//     overrun                      - pulse when line_swap cuts a run short
//   Build option: define PGM_LINEBUF_PRIO_EN to store wr_prio per entry and
//   return it on rd_prio; otherwise rd_prio is 0 and wr_prio is ignored.
module pgm_sprite_linebuf
   import pgm_video_pkg::*;
#(
   parameter int LINE_W = 448,
   parameter int PAL_W  = 5,
   parameter int PIX_W  = 5,
   parameter int XW     = 11
) (
   input  logic                       clk,
   input  logic                       reset_n,
   input  logic                       line_swap,
   input  logic                       wr_valid,
   output logic                       wr_ready,
   input  logic [XW-1:0]              wr_x,
   input  logic [PAL_W-1:0]           wr_pal,
   input  logic                       wr_flipx,
   input  logic                       wr_prio,
   input  logic [63:0]                wr_data,
   input  logic                       rd_en,
   input  logic [$clog2(LINE_W)-1:0]  rd_x,
   output logic                       rd_valid,
   output logic [PAL_W+PIX_W-1:0]     rd_pix,
   output logic                       rd_prio,
   output logic                       overrun
);

   localparam int AW = $clog2(LINE_W);
   localparam int CW = PAL_W + PIX_W;
`ifdef PGM_LINEBUF_PRIO_EN
   localparam int EW = CW + 1;
`else
   localparam int EW = CW;
`endif
   localparam logic [XW:0] X_LIM  = (XW+1)'(LINE_W);
   localparam logic [AW:0] RD_LIM = (AW+1)'(LINE_W);

   wr_state_e        state, state_nx;
   logic [3:0]       k, k_nx;
   logic             rst_done;
   logic             wbank;
   logic             accept;

   logic [XW-1:0]    cmd_x;
   logic [PAL_W-1:0] cmd_pal;
   logic             cmd_flip;
   logic [63:0]      cmd_data;
`ifdef PGM_LINEBUF_PRIO_EN
   logic             cmd_prio;
`else
   logic             unused_prio;
   assign unused_prio = wr_prio;
`endif

   logic [PIX_W-1:0] colour;
   logic [XW:0]      tgt;
   logic             pix_we;
   logic [EW-1:0]    pix_wdata;
   logic             rd_in_range;
   logic [EW-1:0]    bank_rdata [2];
   logic [EW-1:0]    rd_sel;

   // ---------------- writer FSM ----------------
   // rst_done keeps wr_ready low until the first edge after reset release.
   // A swap during EXPAND abandons the run and blocks a same-cycle handshake.
   always_comb begin
      state_nx = state;
      k_nx     = k;
      wr_ready = 1'b0;
      case (state)
         WR_IDLE: begin
            wr_ready = rst_done;
            if (wr_valid && rst_done) begin
               state_nx = WR_EXPAND;
               k_nx     = 4'd0;
            end
         end
         WR_EXPAND: begin
            wr_ready = (k == LAST_K) && !line_swap;
            if (line_swap) begin
               state_nx = WR_IDLE;
               k_nx     = 4'd0;
            end else if (k == LAST_K) begin
               k_nx = 4'd0;
               if (!wr_valid) state_nx = WR_IDLE;
            end else begin
               k_nx = k + 4'd1;
            end
         end
         default: begin
            state_nx = WR_IDLE;
            k_nx     = 4'd0;
         end
      endcase
   end

   assign accept = wr_valid && wr_ready;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state    <= WR_IDLE;
         k        <= 4'd0;
         rst_done <= 1'b0;
         wbank    <= 1'b0;
         overrun  <= 1'b0;
         cmd_x    <= '0;
         cmd_pal  <= '0;
         cmd_flip <= 1'b0;
         cmd_data <= '0;
`ifdef PGM_LINEBUF_PRIO_EN
         cmd_prio <= 1'b0;
`endif
      end else begin
         state    <= state_nx;
         k        <= k_nx;
         rst_done <= 1'b1;
         wbank    <= wbank ^ line_swap;
         overrun  <= (state == WR_EXPAND) && line_swap;
         if (accept) begin
            cmd_x    <= wr_x;
            cmd_pal  <= wr_pal;
            cmd_flip <= wr_flipx;
            cmd_data <= wr_data;
`ifdef PGM_LINEBUF_PRIO_EN
            cmd_prio <= wr_prio;
`endif
         end
      end
   end

   // ---------------- pixel expansion ----------------
   // Target X is one bit wider than wr_x so runs near the right edge clip
   // instead of wrapping onto the left of the line.
   assign colour = PIX_W'(pix_field(cmd_data, k, cmd_flip));
   assign tgt    = {1'b0, cmd_x} + (XW+1)'(k);
   assign pix_we = (state == WR_EXPAND) && !line_swap &&
                   (colour != '0) && (tgt < X_LIM);
`ifdef PGM_LINEBUF_PRIO_EN
   assign pix_wdata = {cmd_prio, cmd_pal, colour};
`else
   assign pix_wdata = {cmd_pal, colour};
`endif

   // ---------------- banks ----------------
   // Writes go to bank wbank, read-and-clear to the other, so the two ports
   // never meet in the same bank. On a swap cycle both still use the
   // pre-swap wbank.
   assign rd_in_range = ({1'b0, rd_x} < RD_LIM);

   for (genvar b = 0; b < 2; b++) begin : g_bank
      pgm_linebuf_bank #(
         .LINE_W (LINE_W),
         .EW     (EW),
         .AW     (AW)
      ) u_bank (
         .clk     (clk),
         .reset_n (reset_n),
         .we      (pix_we && (wbank == 1'(b))),
         .waddr   (tgt[AW-1:0]),
         .wdata   (pix_wdata),
         .clr     (rd_en && rd_in_range && (wbank != 1'(b))),
         .raddr   (rd_x),
         .rdata   (bank_rdata[b])
      );
   end

   assign rd_sel = bank_rdata[!wbank];

   // ---------------- read response ----------------
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rd_valid <= 1'b0;
         rd_pix   <= '0;
      end else begin
         rd_valid <= rd_en;
         if (rd_en) rd_pix <= rd_in_range ? rd_sel[CW-1:0] : '0;
      end
   end

`ifdef PGM_LINEBUF_PRIO_EN
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)   rd_prio <= 1'b0;
      else if (rd_en) rd_prio <= rd_in_range ? rd_sel[EW-1] : 1'b0;
   end
`else
   assign rd_prio = 1'b0;
`endif

endmodule

// File: tb/tb_pgm_sprite_linebuf.sv
// tb_pgm_sprite_linebuf
//   Directed bench for pgm_sprite_linebuf: fills runs, swaps banks, reads the
//   line back and compares against hand-computed pixel values.
module tb_pgm_sprite_linebuf;

   localparam int LINE_W = 448;
   localparam int PAL_W  = 5;
   localparam int PIX_W  = 5;
   localparam int XW     = 11;
   localparam int AW     = $clog2(LINE_W);
   localparam int CW     = PAL_W + PIX_W;

   // every field = 5 : each word 5 | 5<<5 | 5<<10 = 0x14A5
   localparam logic [63:0] D_ALL5 = 64'h14A5_14A5_14A5_14A5;
   // fields 1..12 in order, bit 15 of word 0 set (must be ignored)
   localparam logic [63:0] D_SEQ  = 64'h316A_2507_18A4_8C41;
   // even fields 7, odd fields 0 (transparent)
   localparam logic [63:0] D_ALT7 = 64'h00E0_1C07_00E0_1C07;
   // every field = 9
   localparam logic [63:0] D_ALL9 = 64'h2529_2529_2529_2529;

   // ---------------- clock / reset ----------------
   logic              clk = 1'b0;
   logic              reset_n = 1'b0;
   logic              line_swap = 1'b0;
   logic              wr_valid = 1'b0;
   logic              wr_ready;
   logic [XW-1:0]     wr_x = '0;
   logic [PAL_W-1:0]  wr_pal = '0;
   logic              wr_flipx = 1'b0;
   logic              wr_prio = 1'b0;
   logic [63:0]       wr_data = '0;
   logic              rd_en = 1'b0;
   logic [AW-1:0]     rd_x = '0;
   logic              rd_valid;
   logic [CW-1:0]     rd_pix;
   logic              rd_prio;
   logic              overrun;

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   pgm_sprite_linebuf #(
      .LINE_W (LINE_W),
      .PAL_W  (PAL_W),
      .PIX_W  (PIX_W),
      .XW     (XW)
   ) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .line_swap (line_swap),
      .wr_valid  (wr_valid),
      .wr_ready  (wr_ready),
      .wr_x      (wr_x),
      .wr_pal    (wr_pal),
      .wr_flipx  (wr_flipx),
      .wr_prio   (wr_prio),
      .wr_data   (wr_data),
      .rd_en     (rd_en),
      .rd_x      (rd_x),
      .rd_valid  (rd_valid),
      .rd_pix    (rd_pix),
      .rd_prio   (rd_prio),
      .overrun   (overrun)
   );

   // ---------------- scoreboard ----------------
   int              n_checks = 0;
   int              n_pass   = 0;
   logic [CW-1:0]   exp_q[$];

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   // ---------------- driver tasks ----------------
   // All tasks start and end 1 time unit after a rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic swap();
      line_swap = 1'b1;
      tick();
      line_swap = 1'b0;
   endtask

   // Presents a run and returns right after the accepting edge.
   task automatic send_run(input logic [XW-1:0] x, input logic [PAL_W-1:0] pal,
                           input logic flip, input logic [63:0] data);
      int guard;
      guard    = 0;
      wr_valid = 1'b1;
      wr_x     = x;
      wr_pal   = pal;
      wr_flipx = flip;
      wr_data  = data;
      while (!wr_ready && guard < 40) begin
         tick();
         guard++;
      end
      check($sformatf("wr_ready_wait_x%0d", x), {31'b0, wr_ready}, 32'd1);
      tick();
      wr_valid = 1'b0;
   endtask

   task automatic read_one(input string tag, input int x, input logic [CW-1:0] exp);
      rd_en = 1'b1;
      rd_x  = AW'(x);
      tick();
      rd_en = 1'b0;
      check($sformatf("%s_valid_x%0d", tag, x), {31'b0, rd_valid}, 32'd1);
      check($sformatf("%s_pix_x%0d", tag, x), 32'(rd_pix), 32'(exp));
   endtask

   // Reads consecutive X starting at x0, one per queued expected value.
   task automatic read_q(input string tag, input int x0);
      int i;
      i = 0;
      while (exp_q.size() > 0) begin
         read_one(tag, x0 + i, exp_q.pop_front());
         i++;
      end
   endtask

   // ---------------- stimulus ----------------
   initial begin
      // reset state
      repeat (3) @(posedge clk);
      #1;
      check("rst_wr_ready", {31'b0, wr_ready}, 32'd0);
      check("rst_rd_valid", {31'b0, rd_valid}, 32'd0);
      check("rst_rd_pix",   32'(rd_pix),       32'd0);
      check("rst_rd_prio",  {31'b0, rd_prio},  32'd0);
      check("rst_overrun",  {31'b0, overrun},  32'd0);
      reset_n = 1'b1;
      #1;
      check("rel_wr_ready_same", {31'b0, wr_ready}, 32'd0);
      tick();
      check("rel_wr_ready_next", {31'b0, wr_ready}, 32'd1);

      // S1: x=0, pal 3, all colour 5 -> {3,5} = 0x065
      send_run(11'd0, 5'd3, 1'b0, D_ALL5);
      repeat (12) tick();
      check("s1_no_overrun", {31'b0, overrun}, 32'd0);
      swap();
      for (int i = 0; i < 12; i++) exp_q.push_back(10'h065);
      read_q("s1", 0);
      read_one("s1_reread", 0, 10'h000);
      read_one("s1_past_run", 12, 10'h000);
      tick();
      check("s1_valid_idle", {31'b0, rd_valid}, 32'd0);

      // S2: fields 1..12, flipped, x=100, pal 2 -> x=100+i holds colour 12-i
      send_run(11'd100, 5'd2, 1'b1, D_SEQ);
      repeat (12) tick();
      swap();
      for (int i = 0; i < 12; i++) exp_q.push_back(10'(32'h40 | (12 - i)));
      read_q("s2", 100);

      // S3: back-to-back runs at x=10; run 1 (pal 1) wins where opaque,
      // run 2 (pal 2, colour 9) fills run 1's transparent pixels
      send_run(11'd10, 5'd1, 1'b0, D_ALT7);
      send_run(11'd10, 5'd2, 1'b0, D_ALL9);
      repeat (12) tick();
      swap();
      for (int i = 0; i < 12; i++) exp_q.push_back((i % 2 == 0) ? 10'h027 : 10'h049);
      read_q("s3", 10);
      read_one("s3_past_run", 22, 10'h000);

      // S4: x=440 clips at the right edge, no wrap to the left
      send_run(11'd440, 5'd1, 1'b0, D_ALL5);
      repeat (12) tick();
      swap();
      for (int i = 0; i < 8; i++) exp_q.push_back(10'h025);
      read_q("s4_edge", 440);
      for (int i = 0; i < 4; i++) exp_q.push_back(10'h000);
      read_q("s4_noalias", 0);
      read_one("s4_oob", 450, 10'h000);

      // S5: line_swap while k=5 -> overrun pulse, only pixels 0..4 kept
      send_run(11'd200, 5'd3, 1'b0, D_ALL5);
      repeat (5) tick();
      line_swap = 1'b1;
      #1;
      check("s5_no_accept_on_swap", {31'b0, wr_ready}, 32'd0);
      tick();
      line_swap = 1'b0;
      check("s5_overrun_pulse", {31'b0, overrun}, 32'd1);
      check("s5_back_to_idle", {31'b0, wr_ready}, 32'd1);
      tick();
      check("s5_overrun_clear", {31'b0, overrun}, 32'd0);
      for (int i = 0; i < 5; i++) exp_q.push_back(10'h065);
      for (int i = 0; i < 7; i++) exp_q.push_back(10'h000);
      read_q("s5_old", 200);
      swap();
      for (int i = 0; i < 12; i++) exp_q.push_back(10'h000);
      read_q("s5_new", 200);

      // S6: reset mid-EXPAND -> occupancy gone in both banks
      send_run(11'd300, 5'd3, 1'b0, D_ALL5);
      repeat (6) tick();
      reset_n = 1'b0;
      #1;
      check("s6_rst_wr_ready", {31'b0, wr_ready}, 32'd0);
      check("s6_rst_rd_valid", {31'b0, rd_valid}, 32'd0);
      tick();
      tick();
      reset_n = 1'b1;
      #1;
      check("s6_rel_wr_ready_same", {31'b0, wr_ready}, 32'd0);
      tick();
      check("s6_rel_wr_ready_next", {31'b0, wr_ready}, 32'd1);
      read_one("s6_bank1", 300, 10'h000);
      swap();
      for (int i = 0; i < 6; i++) exp_q.push_back(10'h000);
      read_q("s6_bank0", 300);

      // ---------------- report ----------------
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/pgm_sprite_linebuf.md
PGM_SPRITE_LINEBUF -- requirements
Module: pgm_sprite_linebuf

Interface
REQ-001 SHALL have parameters (name, default, meaning), one per line:
- LINE_W, 448, visible pixels per line.
- PAL_W, 5, palette-select bits.
- PIX_W, 5, colour-index bits.
- XW, 11, sprite X coordinate width.
REQ-002 SHALL have ports (name, direction, width, meaning), one per line:
- clk, in, 1, sole clock.
- reset_n, in, 1, asynchronous active-low reset.
- line_swap, in, 1, single-cycle pulse at line end; exchanges banks.
- wr_valid, in, 1, pixel-run command valid.
- wr_ready, out, 1, command accepted when wr_valid && wr_ready.
- wr_x, in, XW, screen X of run pixel 0.
- wr_pal, in, PAL_W, palette select for the run.
- wr_flipx, in, 1, horizontal flip of the run.
- wr_prio, in, 1, sprite priority bit (PGM_LINEBUF_PRIO_EN only).
- wr_data, in, 64, four A-ROM words, 3 pixels each.
- rd_en, in, 1, display read strobe.
- rd_x, in, $clog2(LINE_W), display read X.
- rd_valid, out, 1, rd_pix/rd_prio valid.
- rd_pix, out, PAL_W+PIX_W, {pal, colour}; 0 means transparent.
- rd_prio, out, 1, stored priority (PGM_LINEBUF_PRIO_EN only).
- overrun, out, 1, one-cycle pulse when a run is cut off by line_swap.

Function
REQ-003 SHALL hold two banks of LINE_W entries plus one occupancy bit per entry; wbank selects the bank being written, and ~wbank is the bank being read.
REQ-004 SHALL toggle wbank on every line_swap pulse.
REQ-005 SHALL implement writer FSM states IDLE and EXPAND; wr_ready=1 in IDLE, and also in EXPAND when k==11.
REQ-006 SHALL, on handshake, capture the command, set k=0 and enter EXPAND; a handshake at k==11 restarts EXPAND back-to-back, otherwise the FSM returns to IDLE after k==11.
REQ-007 SHALL process one pixel per EXPAND cycle (12 cycles per run); field k=3j+i is wr_data[16j+5i+4 : 16j+5i] (bit 16j+15 ignored); with wr_flipx=1, the pixel at offset k is field 11-k.
REQ-008 SHALL compute target X = wr_x + k in XW+1 bits, so no wrap.
REQ-009 SHALL write the target only if colour!=0, target<LINE_W and its occupancy bit is 0 (first-written wins); a write stores {wr_pal, colour} (and wr_prio) and sets occupancy.
REQ-010 SHALL, on line_swap during EXPAND: discard the remaining pixels, pulse overrun the next cycle, go to IDLE, and write no further pixels to the old bank; a handshake in that same cycle is not accepted (wr_ready forced 0).
REQ-011 SHALL, on rd_en, return rd_valid=1 one cycle later with rd_pix = occupied ? entry : 0 from the read bank at rd_x, and clear that entry's occupancy bit (clear-on-read).
REQ-012 SHALL, for rd_x>=LINE_W, return rd_pix=0 with rd_valid=1 and clear nothing.
REQ-013 SHALL, when rd_en and line_swap coincide, read and clear from the pre-swap read bank.
REQ-014 SHALL never allow a write and a clear to target the same bank in one cycle; this is structural via the bank split.

Reset
REQ-015 SHALL, on reset_n=0, asynchronously clear wbank, both occupancy vectors, FSM=IDLE, k, wr_ready=0, rd_valid=0, rd_pix=0, rd_prio=0 and overrun=0; wr_ready rises the first cycle after release.
REQ-016 SHALL leave entry data unreset; occupancy masks stale data.

Configuration
REQ-017 SHALL use macro PGM_LINEBUF_PRIO_EN: when defined, each entry stores wr_prio and rd_prio outputs it; when undefined, wr_prio is ignored, rd_prio is tied to 0 and no priority storage is built.

Structure
REQ-018 SHALL place in package pgm_video_pkg: the writer state enum, constant PIX_PER_RUN=12, and the field-extract function (data, index, flip) -> colour.
REQ-019 SHALL implement storage as sub-module pgm_linebuf_bank (entries + occupancy, one write port, one read-and-clear port), instantiated twice.

Verification
REQ-020 SHALL be verified by these directed scenarios:
- wr_x=0, pal=3, all fields=5, then swap and read x=0..11 -> rd_pix=0x065 each; reread x=0 -> 0.
- wr_data fields 1..12, flipx=1, wr_x=100 -> x=100 reads colour 12, x=111 reads colour 1.
- Two runs at x=10, first pal=1, second pal=2 -> x=10..21 hold pal=1; transparent (0) fields in run 1 are filled by run 2.
- wr_x=440 -> x=440..447 are written, nothing aliases to 0..3; rd_x=450 -> 0, rd_valid=1.
- line_swap at k=5 -> overrun pulse; old bank holds pixels 0..4 only; new bank is empty.
- reset_n low mid-EXPAND -> all reads return 0 afterwards; wr_ready=1 the cycle after release.
